// File: rtl/addsub_result_accum_if.sv
// Handshake bundle between the add/sub stage (master) and the result accumulator (slave).
interface addsub_result_accum_if #(
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       result;
  logic             v;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc;
  logic [7:0]       v_cnt;
  logic             v_seen;
  logic             acc_ovf;

  modport slave (
    input  in_valid, result, v, out_ready,
    output in_ready, out_valid, acc, v_cnt, v_seen, acc_ovf
  );

  modport master (
    output in_valid, result, v, out_ready,
    input  in_ready, out_valid, acc, v_cnt, v_seen, acc_ovf
  );
endinterface

// File: rtl/addsub_result_accum.sv
// Sums NUM_SAMPLES signed add/sub results per block, counts overflowed samples, holds the total.
// Define ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
//   state   | meaning
//   S_IDLE  | waiting for the first sample of a block
//   S_ACCUM | summing the remaining samples
//   S_HOLD  | block total presented until out_ready
module addsub_result_accum #(
  parameter int NUM_SAMPLES = 8,
  parameter int ACC_W       = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  addsub_result_accum_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [7:0]       LP_NUM = 8'(NUM_SAMPLES);
  localparam logic [ACC_W-1:0] LP_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] LP_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_v_cnt;
  logic [7:0]       r_count;
  logic             r_v_seen;
  logic             r_acc_ovf;
  logic             r_out_valid;

  logic             w_accept;
  logic [ACC_W-1:0] w_sext;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_next_acc;
  logic [7:0]       w_count_inc;

  assign bus.in_ready  = ~i_rst & (r_state != S_HOLD);
  assign bus.out_valid = r_out_valid;
  assign bus.acc       = r_acc;
  assign bus.v_cnt     = r_v_cnt;
  assign bus.v_seen    = r_v_seen;
  assign bus.acc_ovf   = r_acc_ovf;

  assign w_accept    = bus.in_valid & bus.in_ready;
  assign w_sext      = {{(ACC_W-8){bus.result[7]}}, bus.result};
  assign w_sum       = r_acc + w_sext;
  assign w_count_inc = r_count + 8'd1;
  // Signed overflow: equal-signed addends whose sum flips sign.
  assign w_ovf = (r_acc[ACC_W-1] == w_sext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef ACC_SAT_EN
  assign w_next_acc = w_ovf ? (r_acc[ACC_W-1] ? LP_MIN : LP_MAX) : w_sum;
`else
  assign w_next_acc = w_sum;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_v_cnt     <= '0;
      r_count     <= '0;
      r_v_seen    <= 1'b0;
      r_acc_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc     <= w_sext;
            r_v_cnt   <= {7'd0, bus.v};
            r_v_seen  <= bus.v;
            r_acc_ovf <= 1'b0;
            r_count   <= 8'd1;
            if (LP_NUM == 8'd1) begin
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc     <= w_next_acc;
            r_v_cnt   <= r_v_cnt + {7'd0, bus.v};
            r_v_seen  <= r_v_seen | bus.v;
            r_acc_ovf <= r_acc_ovf | w_ovf;
            r_count   <= w_count_inc;
            if (w_count_inc == LP_NUM) begin
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_result_accum.sv
// Scoreboard bench: three accumulator instances (4x12, 4x9, 1x12) against a plain-arithmetic model.
module tb_addsub_result_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addsub_result_accum_if #(.ACC_W(12)) bus0 ();
  addsub_result_accum_if #(.ACC_W(9))  bus1 ();
  addsub_result_accum_if #(.ACC_W(12)) bus2 ();

  addsub_result_accum #(.NUM_SAMPLES(4), .ACC_W(12)) u0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  addsub_result_accum #(.NUM_SAMPLES(4), .ACC_W(9))  u1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
  addsub_result_accum #(.NUM_SAMPLES(1), .ACC_W(12)) u2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

  typedef struct {
    int k;
    int acc;
    int vc;
    bit vs;
    bit ao;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode [3];
  int   m_cnt [3];
  int   m_acc [3];
  int   m_vc [3];
  bit   m_vs [3];
  bit   m_ov [3];

  function automatic int ns(int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int aw(int k);
    return (k == 1) ? 9 : 12;
  endfunction

  function automatic bit f_irdy(int k);
    case (k)
      0: return bus0.in_ready;
      1: return bus1.in_ready;
      default: return bus2.in_ready;
    endcase
  endfunction

  function automatic bit f_ov(int k);
    case (k)
      0: return bus0.out_valid;
      1: return bus1.out_valid;
      default: return bus2.out_valid;
    endcase
  endfunction

  function automatic bit f_ordy(int k);
    case (k)
      0: return bus0.out_ready;
      1: return bus1.out_ready;
      default: return bus2.out_ready;
    endcase
  endfunction

  function automatic int f_acc(int k);
    case (k)
      0: return int'($signed(bus0.acc));
      1: return int'($signed(bus1.acc));
      default: return int'($signed(bus2.acc));
    endcase
  endfunction

  function automatic int f_vc(int k);
    case (k)
      0: return int'(bus0.v_cnt);
      1: return int'(bus1.v_cnt);
      default: return int'(bus2.v_cnt);
    endcase
  endfunction

  function automatic bit f_vs(int k);
    case (k)
      0: return bus0.v_seen;
      1: return bus1.v_seen;
      default: return bus2.v_seen;
    endcase
  endfunction

  function automatic bit f_ao(int k);
    case (k)
      0: return bus0.acc_ovf;
      1: return bus1.acc_ovf;
      default: return bus2.acc_ovf;
    endcase
  endfunction

  task automatic drive(int k, bit vld, int r, bit v);
    logic [7:0] rb;
    rb = 8'(r);
    case (k)
      0: begin bus0.in_valid = vld; bus0.result = rb; bus0.v = v; end
      1: begin bus1.in_valid = vld; bus1.result = rb; bus1.v = v; end
      default: begin bus2.in_valid = vld; bus2.result = rb; bus2.v = v; end
    endcase
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: running signed sum with range test; wrap or clamp at the ACC_W limits.
  function automatic bit model_accept(int k, int r, bit v);
    longint lo, hi, s;
    exp_t e;
    lo = -(longint'(1) << (aw(k) - 1));
    hi = (longint'(1) << (aw(k) - 1)) - 1;
    if (m_cnt[k] == 0) begin
      m_acc[k] = r;
      m_vc[k]  = int'(v);
      m_vs[k]  = v;
      m_ov[k]  = 1'b0;
    end else begin
      s = longint'(m_acc[k]) + longint'(r);
      if (s > hi || s < lo) begin
        m_ov[k] = 1'b1;
`ifdef ACC_SAT_EN
        s = (s > hi) ? hi : lo;
`else
        s = (s > hi) ? s - (longint'(1) << aw(k)) : s + (longint'(1) << aw(k));
`endif
      end
      m_acc[k] = int'(s);
      m_vc[k]  = m_vc[k] + int'(v);
      m_vs[k]  = m_vs[k] | v;
    end
    m_cnt[k]++;
    if (m_cnt[k] == ns(k)) begin
      e.k = k; e.acc = m_acc[k]; e.vc = m_vc[k]; e.vs = m_vs[k]; e.ao = m_ov[k];
      sb.push_back(e);
      m_cnt[k] = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic put(int k, int r, bit v, int gap);
    bit ok;
    int n;
    bit done;
    ok = 1'b0;
    n  = 0;
    drive(k, 1'b1, r, v);
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = f_irdy(k);
      @(posedge clk);
      n++;
    end
    #1;
    drive(k, 1'b0, 0, 1'b0);
    if (!ok) begin
      check("accept_timeout", 0, 1);
      return;
    end
    done = model_accept(k, r, v);
    if (done) check("out_valid_latency", int'(f_ov(k)), 1);
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic wait_drain(int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("scoreboard_drained", sb.size(), 0);
  endtask

  // Monitor: every presented block must match the head expectation for that instance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 3; k++) begin
          if (f_ov(k)) begin
            int idx;
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
              if (idx < 0 && sb[i].k == k) idx = i;
            check("in_ready_low_in_hold", int'(f_irdy(k)), 0);
            checks++;
            if (idx < 0) begin
              errors++;
              $display("FAIL unexpected_out_valid: inst %0d acc %0d with nothing expected", k, f_acc(k));
            end else begin
              if (f_acc(k) != sb[idx].acc || f_vc(k) != sb[idx].vc ||
                  f_vs(k) != sb[idx].vs || f_ao(k) != sb[idx].ao) begin
                errors++;
                $display("FAIL block_result: inst %0d got acc=%0d vc=%0d vs=%0d ovf=%0d expected acc=%0d vc=%0d vs=%0d ovf=%0d",
                         k, f_acc(k), f_vc(k), f_vs(k), f_ao(k),
                         sb[idx].acc, sb[idx].vc, sb[idx].vs, sb[idx].ao);
              end
              if (f_ordy(k)) sb.delete(idx);
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus0.out_ready = (rdy_mode[0] == 2) || (rdy_mode[0] == 0 && $urandom_range(0, 3) != 0);
      bus1.out_ready = (rdy_mode[1] == 2) || (rdy_mode[1] == 0 && $urandom_range(0, 3) != 0);
      bus2.out_ready = (rdy_mode[2] == 2) || (rdy_mode[2] == 0 && $urandom_range(0, 3) != 0);
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rdy_mode[k] = 0;
      m_cnt[k] = 0;
      drive(k, 1'b0, 0, 1'b0);
    end
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    bus2.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("in_ready_in_reset", int'(f_irdy(k)), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_acc", f_acc(k), 0);
      check("reset_out_valid", int'(f_ov(k)), 0);
      check("reset_v_cnt", f_vc(k), 0);
    end

    // Directed blocks on the 4x12 instance
    put(0, 10, 0, 0); put(0, 20, 0, 0); put(0, 30, 0, 0); put(0, 40, 0, 0);
    wait_drain(50);
    for (int i = 0; i < 4; i++) put(0, -128, 0, 0);
    wait_drain(50);
    put(0, 1, 1, 0); put(0, 1, 0, 0); put(0, 1, 1, 0); put(0, 1, 1, 0);
    wait_drain(50);

    // HOLD with out_ready low and in_valid high
    rdy_mode[0] = 1;
    put(0, 5, 0, 0); put(0, 6, 1, 0); put(0, 7, 0, 0); put(0, 8, 0, 0);
    drive(0, 1'b1, 99, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", int'(f_irdy(0)), 0);
      check("hold_out_valid", int'(f_ov(0)), 1);
    end
    rdy_mode[0] = 2;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("out_valid_drop", int'(f_ov(0)), 0);
    put(0, 99, 0, 0);
    rdy_mode[0] = 0;
    put(0, 1, 0, 0); put(0, 2, 0, 0); put(0, 3, 0, 0);
    wait_drain(50);

    // Reset aborts a partial block
    put(0, 5, 0, 0); put(0, 5, 1, 0);
    rst = 1'b1;
    #1;
    check("in_ready_during_rst", int'(f_irdy(0)), 0);
    @(posedge clk);
    #1;
    check("rst_acc", f_acc(0), 0);
    check("rst_v_cnt", f_vc(0), 0);
    check("rst_v_seen", int'(f_vs(0)), 0);
    check("rst_acc_ovf", int'(f_ao(0)), 0);
    check("rst_out_valid", int'(f_ov(0)), 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    for (int i = 0; i < 4; i++) put(0, 5, 0, 0);
    wait_drain(50);

    // Narrow accumulator overflow and single-sample blocks
    for (int i = 0; i < 4; i++) put(1, 127, 0, 0);
    wait_drain(50);
    put(2, -3, 0, 0);
    wait_drain(50);

    // Randomized blocks on every instance
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 15 * ns(k); b++)
        put(k, int'($urandom_range(0, 255)) - 128, ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 2)));
      for (int b = 0; b < 4 * ns(k); b++)
        put(k, ($urandom_range(0, 1) == 1) ? 127 : -128, 1'b0, 0);
    end
    wait_drain(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
